// File: rtl/fx2_cmd_pkg.sv
// ---------------------------------------------------------------------------
// fx2_cmd_pkg
// Shared constants, state encoding and frame payload type for the FX2
// register-command responder and its reply serializer.
// ---------------------------------------------------------------------------
package fx2_cmd_pkg;

   // Frame markers and opcodes
   localparam logic [7:0]  SYNC_BYTE = 8'hAA;
   localparam logic [7:0]  OP_READ   = 8'h00;
   localparam logic [7:0]  OP_WRITE  = 8'h01;

   // Frame geometry: sync + op + address bytes + value bytes
   localparam int unsigned FRAME_LEN  = 8;
   localparam int unsigned REPLY_LEN  = 4;
   localparam int unsigned ADDR_BYTES = 2;
   localparam int unsigned VAL_BYTES  = FRAME_LEN - 2 - ADDR_BYTES;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   // Reply value returned when the register bus never acknowledges
   localparam logic [DATA_W-1:0] REPLY_TIMEOUT_VAL = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_OP    = 3'd1,
      ST_ADDR  = 3'd2,
      ST_VAL   = 3'd3,
      ST_BUS   = 3'd4,
      ST_REPLY = 3'd5
   } state_e;

   // Register request captured from one frame
   typedef struct packed {
      logic              is_wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } reg_req_t;

endpackage

// File: rtl/fx2_reply_serializer.sv
// ---------------------------------------------------------------------------
// fx2_reply_serializer
// Loads a 32-bit reply word and emits it LSB-first as 4 bytes over a
// valid/ready byte interface.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load_i          load load_data_i and start emitting (only while idle)
//   load_data_i     32-bit reply word
//   ready_i         downstream ready
//   valid_o         byte valid (registered)
//   data_o          current byte, stable while valid_o & !ready_i
//   done_c_o        combinational: the final byte handshakes this cycle
// ---------------------------------------------------------------------------
module fx2_reply_serializer
   import fx2_cmd_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [7:0]        data_o,
   output logic              done_c_o
);

   localparam int unsigned CNT_W = $clog2(REPLY_LEN);

   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              hs_c;

   assign hs_c     = valid_q & ready_i;
   assign done_c_o = hs_c && (cnt_q == CNT_W'(REPLY_LEN - 1));
   assign valid_o  = valid_q;
   assign data_o   = shift_q[7:0];

   // Next-state: load, or shift one byte out per handshake
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (load_i) begin
         shift_d = load_data_i;
         cnt_d   = '0;
         valid_d = 1'b1;
      end else if (hs_c) begin
         shift_d = {8'h00, shift_q[DATA_W-1:8]};
         cnt_d   = cnt_q + CNT_W'(1);
         if (done_c_o) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/fx2_reg_cmd_responder.sv
// ---------------------------------------------------------------------------
// fx2_reg_cmd_responder
// Parses 8-byte host command frames (AA, op, addr LE16, val LE32) from the
// FX2 command byte stream, issues one register read or write per frame and
// returns the 32-bit bus result as a 4-byte LSB-first reply.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cmd_data/valid/ready         command byte stream in
//   reply_data/valid/ready       reply byte stream out
//   reg_addr, reg_wdata          captured request, held until the next frame
//   reg_wr, reg_rd               one-cycle bus strobes
//   reg_rdata, reg_ack           bus completion and returned data
//   busy                         not in IDLE
//   timeout_err                  pulse: bus never acknowledged
//   frame_abort                  pulse: bad opcode or inter-byte timeout
// ---------------------------------------------------------------------------
module fx2_reg_cmd_responder
   import fx2_cmd_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT  = 16,
   parameter int unsigned BYTE_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        cmd_data,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   output logic [7:0]        reply_data,
   output logic              reply_valid,
   input  logic              reply_ready,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic              reg_ack,
   output logic              busy,
   output logic              timeout_err,
   output logic              frame_abort
);

   localparam int unsigned ACK_CNT_W  = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned BYTE_CNT_W = $clog2(BYTE_TIMEOUT + 1);
   localparam int unsigned IDX_W      = 3;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   reg_req_t              req_q, req_d;
   logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [ACK_CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
   logic                  reg_rd_q, reg_rd_d;
   logic                  reg_wr_q, reg_wr_d;
   logic                  timeout_err_q, timeout_err_d;
   logic                  frame_abort_q, frame_abort_d;

   logic                  in_frame_c;
   logic                  cmd_acc_c;
   logic                  ser_load_c;
   logic [DATA_W-1:0]     ser_data_c;
   logic                  ser_done_c;

   // Byte acceptance is a pure state decode so it reads 1 while in reset
   assign in_frame_c = (state_q == ST_OP) || (state_q == ST_ADDR) || (state_q == ST_VAL);
   assign cmd_ready  = (state_q == ST_IDLE) || in_frame_c;
   assign cmd_acc_c  = cmd_valid & cmd_ready;

   assign busy        = (state_q != ST_IDLE);
   assign reg_addr    = req_q.addr;
   assign reg_wdata   = req_q.wdata;
   assign reg_rd      = reg_rd_q;
   assign reg_wr      = reg_wr_q;
   assign timeout_err = timeout_err_q;
   assign frame_abort = frame_abort_q;

   // Frame parser, bus handshake and reply sequencing
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      req_d         = req_q;
      byte_cnt_d    = byte_cnt_q;
      ack_cnt_d     = ack_cnt_q;
      reg_rd_d      = 1'b0;
      reg_wr_d      = 1'b0;
      timeout_err_d = 1'b0;
      frame_abort_d = 1'b0;
      ser_load_c    = 1'b0;
      ser_data_c    = '0;

      unique case (state_q)
         ST_IDLE: begin
            // Anything other than the sync marker is silently dropped
            if (cmd_acc_c && (cmd_data == SYNC_BYTE)) begin
               state_d = ST_OP;
            end
         end

         ST_OP: begin
            if (cmd_acc_c) begin
               if ((cmd_data == OP_READ) || (cmd_data == OP_WRITE)) begin
                  req_d.is_wr = (cmd_data == OP_WRITE);
                  idx_d       = '0;
                  state_d     = ST_ADDR;
               end else begin
                  frame_abort_d = 1'b1;
                  state_d       = ST_IDLE;
               end
            end
         end

         ST_ADDR: begin
            if (cmd_acc_c) begin
               req_d.addr[{idx_q[0], 3'b000} +: 8] = cmd_data;
               if (idx_q == IDX_W'(ADDR_BYTES - 1)) begin
                  idx_d   = '0;
                  state_d = ST_VAL;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         ST_VAL: begin
            if (cmd_acc_c) begin
               req_d.wdata[{idx_q[1:0], 3'b000} +: 8] = cmd_data;
               if (idx_q == IDX_W'(VAL_BYTES - 1)) begin
                  idx_d     = '0;
                  reg_rd_d  = ~req_q.is_wr;
                  reg_wr_d  = req_q.is_wr;
                  ack_cnt_d = '0;
                  state_d   = ST_BUS;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         ST_BUS: begin
            // Ack counts from the strobe cycle itself; the timeout wins only
            // after ACK_TIMEOUT cycles without one
            if (reg_ack) begin
               ser_load_c = 1'b1;
               ser_data_c = reg_rdata;
               state_d    = ST_REPLY;
            end else if (ack_cnt_q == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
               ser_load_c    = 1'b1;
               ser_data_c    = REPLY_TIMEOUT_VAL;
               timeout_err_d = 1'b1;
               state_d       = ST_REPLY;
            end else begin
               ack_cnt_d = ack_cnt_q + ACK_CNT_W'(1);
            end
         end

         ST_REPLY: begin
            if (ser_done_c) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Inter-byte idle watchdog, active only while a frame is being collected
      if (in_frame_c) begin
         if (cmd_acc_c) begin
            byte_cnt_d = '0;
         end else if (byte_cnt_q == BYTE_CNT_W'(BYTE_TIMEOUT - 1)) begin
            frame_abort_d = 1'b1;
            state_d       = ST_IDLE;
         end else begin
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
         end
      end else begin
         byte_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         req_q         <= '0;
         byte_cnt_q    <= '0;
         ack_cnt_q     <= '0;
         reg_rd_q      <= 1'b0;
         reg_wr_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         req_q         <= req_d;
         byte_cnt_q    <= byte_cnt_d;
         ack_cnt_q     <= ack_cnt_d;
         reg_rd_q      <= reg_rd_d;
         reg_wr_q      <= reg_wr_d;
         timeout_err_q <= timeout_err_d;
         frame_abort_q <= frame_abort_d;
      end
   end

   fx2_reply_serializer u_reply_ser (
      .clk         (clk),
      .rst_n       (reset_n),
      .load_i      (ser_load_c),
      .load_data_i (ser_data_c),
      .ready_i     (reply_ready),
      .valid_o     (reply_valid),
      .data_o      (reply_data),
      .done_c_o    (ser_done_c)
   );

endmodule

// File: tb/tb_fx2_reg_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_fx2_reg_cmd_responder
// Frame-level bench: sends command frames, plays the register bus with a
// chosen ack latency, and compares each reply against the value a host
// would expect (returned data, or all-ones when the bus never answers).
// ---------------------------------------------------------------------------
module tb_fx2_reg_cmd_responder;

   localparam int ACK_TO  = 16;
   localparam int BYTE_TO = 1024;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  reply_data;
   logic        reply_valid;
   logic        reply_ready;
   logic [15:0] reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic        busy;
   logic        timeout_err;
   logic        frame_abort;

   always #5 clk = ~clk;

   fx2_reg_cmd_responder #(.ACK_TIMEOUT(ACK_TO), .BYTE_TIMEOUT(BYTE_TO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .reply_data  (reply_data),
      .reply_valid (reply_valid),
      .reply_ready (reply_ready),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_wr      (reg_wr),
      .reg_rd      (reg_rd),
      .reg_rdata   (reg_rdata),
      .reg_ack     (reg_ack),
      .busy        (busy),
      .timeout_err (timeout_err),
      .frame_abort (frame_abort)
   );

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Bus responder / event monitor state
   int          ack_lat = -1;   // -1: never acknowledge
   logic [31:0] ack_val = '0;
   int          strobe_cnt = 0, strobe_cycle = 0;
   int          to_cnt = 0, to_cycle = 0, abort_cnt = 0;
   logic [15:0] strobe_addr = '0;
   logic [31:0] strobe_wdata = '0;
   bit          strobe_wr = 0, busy_seen = 0, rv_seen = 0;

   // Register bus model: acknowledges ack_lat cycles after the strobe
   initial begin : bus_model
      int cd;
      bit pend;
      pend = 0;
      cd = 0;
      reg_ack = 1'b0;
      reg_rdata = '0;
      forever begin
         @(negedge clk);
         reg_ack = 1'b0;
         reg_rdata = $urandom;
         if (!reset_n) begin
            pend = 0;
         end else begin
            if (pend) begin
               if (cd == 0) begin
                  reg_ack = 1'b1;
                  reg_rdata = ack_val;
                  pend = 0;
               end else begin
                  cd--;
               end
            end
            if (reg_rd || reg_wr) begin
               strobe_cnt++;
               strobe_cycle = cyc;
               strobe_addr = reg_addr;
               strobe_wdata = reg_wdata;
               strobe_wr = reg_wr;
               if (ack_lat == 0) begin
                  reg_ack = 1'b1;
                  reg_rdata = ack_val;
               end else if (ack_lat > 0) begin
                  pend = 1;
                  cd = ack_lat - 1;
               end
            end
            if (timeout_err) begin
               to_cnt++;
               to_cycle = cyc;
            end
            if (frame_abort) abort_cnt++;
            if (busy) busy_seen = 1;
            if (reply_valid) rv_seen = 1;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_data = b;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data = 8'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [15:0] addr, input logic [31:0] val);
      logic [63:0] fr;
      fr = {val, addr, op, 8'hAA};
      for (int i = 0; i < 8; i++) send_byte(fr[8*i +: 8]);
   endtask

   // Collects 4 reply bytes with random backpressure plus an optional
   // 20-cycle stall at byte stall_byte
   task automatic collect_reply(input int stall_pct, input int stall_byte, output logic [31:0] got);
      int k, n, stall_left;
      logic [7:0] held;
      bit have_held, rr;
      k = 0; n = 0; stall_left = 20; have_held = 0; got = '0; held = '0;
      while (k < 4 && n < 500) begin
         if (reply_valid) begin
            if (have_held) chk("hold_data", 32'(reply_data), 32'(held));
            chk("reply_cmd_ready", 32'(cmd_ready), 32'd0);
            if (k == stall_byte && stall_left > 0) begin
               rr = 0;
               stall_left--;
            end else begin
               rr = ($urandom_range(0, 99) >= stall_pct);
            end
            reply_ready = rr;
            if (rr) begin
               got[8*k +: 8] = reply_data;
               k++;
               have_held = 0;
            end else begin
               held = reply_data;
               have_held = 1;
            end
         end else begin
            reply_ready = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      reply_ready = 1'b0;
      chk("reply_bytes", 32'(k), 32'd4);
   endtask

   task automatic run_frame(input logic [7:0] op, input logic [15:0] addr, input logic [31:0] val,
                            input logic [31:0] rdata, input int lat, input int stall_pct,
                            input int stall_byte);
      int s0, t0;
      bit acked;
      logic [31:0] got, exp;
      ack_lat = lat;
      ack_val = rdata;
      s0 = strobe_cnt;
      t0 = to_cnt;
      send_frame(op, addr, val);
      chk("bus_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bus_busy", 32'(busy), 32'd1);
      collect_reply(stall_pct, stall_byte, got);
      acked = (lat >= 0) && (lat < ACK_TO);
      exp = acked ? rdata : 32'hFFFF_FFFF;
      chk("reply", got, exp);
      chk("strobe_n", 32'(strobe_cnt - s0), 32'd1);
      chk("strobe_wr", 32'(strobe_wr), 32'(op == 8'h01));
      chk("strobe_addr", 32'(strobe_addr), 32'(addr));
      chk("strobe_wdata", strobe_wdata, val);
      chk("timeout_n", 32'(to_cnt - t0), acked ? 32'd0 : 32'd1);
      if (!acked) chk("timeout_lat", 32'(to_cycle - strobe_cycle), 32'(ACK_TO));
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_reply_valid", 32'(reply_valid), 32'd0);
      chk("addr_hold", 32'(reg_addr), 32'(addr));
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got=running exp=done");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int s0, a0, n, r, lat, ng;
      logic [7:0] b;
      reset_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_data = '0;
      reply_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_reply_valid", 32'(reply_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_reg_addr", 32'(reg_addr), 32'd0);
      chk("rst_reg_wdata", reg_wdata, 32'd0);
      chk("rst_strobes", 32'({reg_rd, reg_wr}), 32'd0);
      chk("rst_pulses", 32'({timeout_err, frame_abort}), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_data = 8'hAA;
      repeat (2) @(negedge clk);
      chk("rst_no_consume", 32'(busy), 32'd0);
      cmd_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Garbage bytes are dropped silently
      busy_seen = 0; rv_seen = 0; s0 = strobe_cnt; a0 = abort_cnt;
      repeat (3) send_byte(8'hFF);
      repeat (3) @(negedge clk);
      chk("garbage_busy", 32'(busy_seen), 32'd0);
      chk("garbage_reply", 32'(rv_seen), 32'd0);
      chk("garbage_strobe", 32'(strobe_cnt - s0), 32'd0);
      chk("garbage_abort", 32'(abort_cnt - a0), 32'd0);

      // Directed frames
      run_frame(8'h00, 16'h0001, 32'h0, 32'h0000_0003, 1, 0, -1);
      run_frame(8'h01, 16'h0003, 32'h4, 32'h0000_0004, 1, 0, -1);
      run_frame(8'h00, 16'h0002, 32'h0, 32'($urandom), -1, 0, -1);
      run_frame(8'h00, 16'h0010, 32'h0, 32'h1122_3344, 2, 0, 1);
      run_frame(8'h01, 16'hAAAA, 32'hAAAA_AAAA, 32'($urandom), 0, 30, -1);
      run_frame(8'h00, 16'h0007, 32'h0, 32'h5A5A_0F0F, 15, 0, -1);
      run_frame(8'h00, 16'h0008, 32'h0, 32'h1234_5678, 16, 0, -1);

      // Inter-byte timeout
      a0 = abort_cnt; s0 = strobe_cnt;
      send_byte(8'hAA); send_byte(8'h00); send_byte(8'h01);
      n = 0;
      while (!frame_abort && n < BYTE_TO + 100) begin
         @(negedge clk);
         n++;
      end
      chk("byte_to_cycles", 32'(n), 32'(BYTE_TO));
      chk("byte_to_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("byte_to_abort_n", 32'(abort_cnt - a0), 32'd1);
      chk("byte_to_strobe", 32'(strobe_cnt - s0), 32'd0);
      run_frame(8'h00, 16'h0021, 32'h0, 32'hCAFE_F00D, 3, 20, -1);

      // Bad opcode
      a0 = abort_cnt; s0 = strobe_cnt;
      send_byte(8'hAA); send_byte(8'h02);
      chk("bad_op_abort", 32'(frame_abort), 32'd1);
      chk("bad_op_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("bad_op_abort_n", 32'(abort_cnt - a0), 32'd1);
      chk("bad_op_strobe", 32'(strobe_cnt - s0), 32'd0);
      run_frame(8'h01, 16'h0042, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4, 0, -1);

      // Reset while a reply is pending
      ack_lat = 1;
      ack_val = 32'h0BAD_0BAD;
      send_frame(8'h00, 16'h0005, 32'h0);
      n = 0;
      while (!reply_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rr_reply_valid", 32'(reply_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rr_valid_drop", 32'(reply_valid), 32'd0);
      chk("rr_busy", 32'(busy), 32'd0);
      chk("rr_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rr_addr", 32'(reg_addr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rr_after_busy", 32'(busy), 32'd0);
      chk("rr_after_valid", 32'(reply_valid), 32'd0);
      run_frame(8'h00, 16'h0006, 32'h0, 32'h0000_0066, 0, 0, -1);

      // Randomized frames with garbage prefix, backpressure and varied ack latency
      for (int f = 0; f < 30; f++) begin
         ng = $urandom_range(0, 3);
         for (int g = 0; g < ng; g++) begin
            b = 8'($urandom);
            if (b == 8'hAA) b = 8'h55;
            send_byte(b);
         end
         r = $urandom_range(0, 9);
         if (r < 7)      lat = $urandom_range(0, 15);
         else if (r < 9) lat = $urandom_range(16, 20);
         else            lat = -1;
         run_frame(8'($urandom_range(0, 1)), 16'($urandom), 32'($urandom), 32'($urandom),
                   lat, $urandom_range(0, 50), -1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
